// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states (IDLE, RUN, HALTED)
//   *_MSB/_LSB    : bit positions of the instruction fields
//   SUS_OPC/SUS_F : suspend encoding driven into invalid slots so the decoder
//                   asserts no writes
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int OPC_MSB   = 8;
  localparam int OPC_LSB   = 5;
  localparam int F_BIT     = 4;
  localparam int RADDR_MSB = 3;
  localparam int RADDR_LSB = 0;

  localparam logic [3:0] SUS_OPC   = 4'b1111;
  localparam logic       SUS_F     = 1'b1;
  localparam logic [3:0] IDLE_RADDR = 4'b0000;

endpackage

// File: rtl/branch_lut.sv
// branch_lut: combinational table mapping a 4-bit target index (taken from the
// instruction's low nibble) to a full program-counter value for jumps and
// taken branches. Contents are program specific.
//   idx_i    in  4     target index
//   target_o out PC_W  jump/branch destination
module branch_lut #(
  parameter int PC_W = 10
) (
  input  logic [3:0]      idx_i,
  output logic [PC_W-1:0] target_o
);

  always_comb begin
    target_o = '0;
    case (idx_i)
      4'd0:  target_o = PC_W'(10'h000);
      4'd1:  target_o = PC_W'(10'h010);
      4'd2:  target_o = PC_W'(10'h020);
      4'd3:  target_o = PC_W'(10'h080);
      4'd4:  target_o = PC_W'(10'h100);
      4'd5:  target_o = PC_W'(10'h200);
      4'd6:  target_o = PC_W'(10'h300);
      4'd7:  target_o = PC_W'(10'h3FF);
      4'd8:  target_o = PC_W'(10'h042);
      4'd9:  target_o = PC_W'(10'h025);
      4'd10: target_o = PC_W'(10'h155);
      4'd11: target_o = PC_W'(10'h2AA);
      4'd12: target_o = PC_W'(10'h0F0);
      4'd13: target_o = PC_W'(10'h30F);
      4'd14: target_o = PC_W'(10'h3F0);
      4'd15: target_o = PC_W'(10'h001);
      default: target_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program counter / fetch stage feeding the control decoder.
//   CLK, reset_n         clock, asynchronous active-low reset
//   start, start_addr    1-cycle pulse loads PC from start_addr and runs
//   instr_in             ROM data at pc_out (combinational ROM)
//   halt_ctrl, j, br_ne, br_lt   decoder control for the current instruction
//   ne_flag, lt_flag     branch condition flags
//   pc_out               ROM address
//   instr_valid          high only while running
//   opcode, f, raddr1    instruction fields, suspend encoding when not valid
//   done                 high while halted
//   cycle_count          running cycles since the last start (saturating)
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W   = 10,
  parameter int INST_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  input  logic [INST_W-1:0] instr_in,
  input  logic              halt_ctrl,
  input  logic              j,
  input  logic              br_ne,
  input  logic              br_lt,
  input  logic              ne_flag,
  input  logic              lt_flag,
  output logic [PC_W-1:0]   pc_out,
  output logic              instr_valid,
  output logic [3:0]        opcode,
  output logic              f,
  output logic [3:0]        raddr1,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_count
);

  fetch_state_t      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   lut_target;
  logic              redirect;

  branch_lut #(.PC_W(PC_W)) u_branch_lut (
    .idx_i    (instr_in[RADDR_MSB:RADDR_LSB]),
    .target_o (lut_target)
  );

  // j takes precedence over branches only in the sense that any of them
  // selects the same table entry; halt is resolved before this is used.
  assign redirect = j | (br_ne & ne_flag) | (br_lt & lt_flag);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (start) begin
      // start reloads from any state, overriding halt and redirects
      state_d = RUN;
      pc_d    = start_addr;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          // the suspend cycle itself is counted
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (halt_ctrl) begin
            state_d = HALTED;          // pc stays on the SUS instruction
          end else if (redirect) begin
            pc_d = lut_target;
          end else begin
            pc_d = pc_q + PC_W'(1);    // wraps naturally at 2**PC_W
          end
        end
        default: begin
          // IDLE and HALTED hold everything; control inputs are ignored
        end
      endcase
    end
  end

  assign pc_out      = pc_q;
  assign instr_valid = (state_q == RUN);
  assign done        = (state_q == HALTED);
  assign cycle_count = cnt_q;

  assign opcode = instr_valid ? instr_in[OPC_MSB:OPC_LSB]     : SUS_OPC;
  assign f      = instr_valid ? instr_in[F_BIT]               : SUS_F;
  assign raddr1 = instr_valid ? instr_in[RADDR_MSB:RADDR_LSB] : IDLE_RADDR;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios with literal expectations followed by a
// randomized run, all checked each cycle against a behavioural model.
module tb_instr_fetch;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        start;
  logic [9:0]  start_addr;
  logic [8:0]  instr_in;
  logic        halt_ctrl, j, br_ne, br_lt, ne_flag, lt_flag;
  logic [9:0]  pc_out;
  logic        instr_valid;
  logic [3:0]  opcode;
  logic        f;
  logic [3:0]  raddr1;
  logic        done;
  logic [15:0] cycle_count;

  int vectors = 0;
  int errors  = 0;

  always #5 CLK = ~CLK;

  instr_fetch #(.PC_W(10), .INST_W(9), .CNT_W(16)) dut (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .start       (start),
    .start_addr  (start_addr),
    .instr_in    (instr_in),
    .halt_ctrl   (halt_ctrl),
    .j           (j),
    .br_ne       (br_ne),
    .br_lt       (br_lt),
    .ne_flag     (ne_flag),
    .lt_flag     (lt_flag),
    .pc_out      (pc_out),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .f           (f),
    .raddr1      (raddr1),
    .done        (done),
    .cycle_count (cycle_count)
  );

  // program's target table
  logic [9:0] lut [16] = '{10'h000, 10'h010, 10'h020, 10'h080,
                           10'h100, 10'h200, 10'h300, 10'h3FF,
                           10'h042, 10'h025, 10'h155, 10'h2AA,
                           10'h0F0, 10'h30F, 10'h3F0, 10'h001};

  // behavioural model: 0 idle, 1 running, 2 halted
  int          m_mode = 0;
  logic [9:0]  m_pc   = 10'h000;
  int          m_cnt  = 0;

  always @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= 0;
      m_pc   <= 10'h000;
      m_cnt  <= 0;
    end else if (start) begin
      m_mode <= 1;
      m_pc   <= start_addr;
      m_cnt  <= 0;
    end else if (m_mode == 1) begin
      m_cnt <= (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      if (halt_ctrl)                                    m_mode <= 2;
      else if (j || (br_ne && ne_flag) || (br_lt && lt_flag)) m_pc <= lut[instr_in[3:0]];
      else                                              m_pc <= 10'((int'(m_pc) + 1) % 1024);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge CLK) begin
    logic v;
    v = (m_mode == 1);
    chk("pc_out",      32'(pc_out),      32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(v));
    chk("done",        32'(done),        32'(m_mode == 2));
    chk("cycle_count", 32'(cycle_count), 32'(m_cnt));
    chk("opcode",      32'(opcode),      v ? 32'(instr_in[8:5]) : 32'hF);
    chk("f",           32'(f),           v ? 32'(instr_in[4])   : 32'h1);
    chk("raddr1",      32'(raddr1),      v ? 32'(instr_in[3:0]) : 32'h0);
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic clr_ctl();
    halt_ctrl = 1'b0; j = 1'b0; br_ne = 1'b0; br_lt = 1'b0;
    ne_flag = 1'b0; lt_flag = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1; start = 1'b0; start_addr = '0; instr_in = 9'h0A3;
    clr_ctl();
    #1 reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("idle_pc", 32'(pc_out), 32'h0);
    chk("idle_valid", 32'(instr_valid), 32'h0);

    // plain sequential fetch from 0x010
    start_addr = 10'h010; start = 1'b1; tick(); start = 1'b0;
    instr_in = 9'h0A3;
    chk("start_pc", 32'(pc_out), 32'h010);
    chk("start_cnt", 32'(cycle_count), 32'h0);
    repeat (5) tick();
    chk("seq_pc", 32'(pc_out), 32'h015);
    chk("seq_cnt", 32'(cycle_count), 32'd5);

    // jump via lut[3], BNE not taken then taken via lut[5]
    start_addr = 10'h100; start = 1'b1; tick(); start = 1'b0;
    j = 1'b1; instr_in = {4'h2, 1'b0, 4'd3}; tick(); j = 1'b0;
    chk("jump_pc", 32'(pc_out), 32'h080);
    br_ne = 1'b1; ne_flag = 1'b0; instr_in = {4'h3, 1'b0, 4'd5}; tick();
    chk("bne_nt_pc", 32'(pc_out), 32'h081);
    ne_flag = 1'b1; tick();
    chk("bne_t_pc", 32'(pc_out), 32'h200);
    clr_ctl();

    // BLT taken at the top address, lands on 0x042 via lut[8]
    start_addr = 10'h3FF; start = 1'b1; tick(); start = 1'b0;
    br_lt = 1'b1; lt_flag = 1'b1; instr_in = {4'h4, 1'b0, 4'd8}; tick();
    clr_ctl();
    chk("blt_pc", 32'(pc_out), 32'h042);

    // suspend at 0x042
    halt_ctrl = 1'b1; instr_in = 9'h1F0; tick(); halt_ctrl = 1'b0;
    instr_in = 9'h0A5;
    chk("halt_done", 32'(done), 32'h1);
    chk("halt_pc", 32'(pc_out), 32'h042);
    chk("halt_opc", 32'(opcode), 32'hF);
    chk("halt_f", 32'(f), 32'h1);
    chk("halt_raddr", 32'(raddr1), 32'h0);
    chk("halt_cnt", 32'(cycle_count), 32'd2);
    j = 1'b1; repeat (3) tick(); j = 1'b0;
    chk("halt_hold_pc", 32'(pc_out), 32'h042);
    chk("halt_hold_cnt", 32'(cycle_count), 32'd2);

    // restart from HALTED at the top address, then wrap
    start_addr = 10'h3FF; start = 1'b1; tick(); start = 1'b0;
    chk("restart_done", 32'(done), 32'h0);
    chk("restart_pc", 32'(pc_out), 32'h3FF);
    chk("restart_cnt", 32'(cycle_count), 32'h0);
    instr_in = 9'h0A3; tick();
    chk("wrap_pc", 32'(pc_out), 32'h000);
    chk("wrap_cnt", 32'(cycle_count), 32'd1);

    // start while running beats a simultaneous jump
    start_addr = 10'h025; start = 1'b1; j = 1'b1; tick(); start = 1'b0; j = 1'b0;
    chk("rerun_pc", 32'(pc_out), 32'h025);
    chk("rerun_cnt", 32'(cycle_count), 32'h0);

    // asynchronous reset mid-run
    reset_n = 1'b0;
    #1;
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_cnt", 32'(cycle_count), 32'h0);
    tick();
    reset_n = 1'b1;

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      reset_n    = ($urandom_range(0, 199) != 0);
      start      = ($urandom_range(0, 19) == 0);
      start_addr = 10'($urandom);
      instr_in   = 9'($urandom);
      halt_ctrl  = ($urandom_range(0, 24) == 0);
      j          = ($urandom_range(0, 7) == 0);
      br_ne      = 1'($urandom);
      br_lt      = 1'($urandom);
      ne_flag    = 1'($urandom);
      lt_flag    = 1'($urandom);
      tick();
    end

    reset_n = 1'b1; start = 1'b0; clr_ctl();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
